// File: rtl/tensor_core_matrix_loader.sv
// tensor_core_matrix_loader
// Streams the 18 signed operand elements of two 3x3 matrices from a byte-wide
// valid/ready source into the tensor core register file. Elements 0-15 go out
// as four quad writes; elements 16 and 17 go out as single non-bulk writes.
//
// Handshake: an element is transferred on a rising edge where data_valid_in and
// data_ready_out are both high. data_ready_out is combinational and high only
// in COLLECT with abort_in low. The source may drop valid at any time.
// Abort takes priority over a same-cycle handshake.
module tensor_core_matrix_loader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    output logic                  quad_write_enable_out,
    output logic [2:0]            quad_write_register_address_out,
    output logic [DATA_WIDTH-1:0] quad_write_data_out [4],
    output logic                  non_bulk_write_enable_out,
    output logic [4:0]            non_bulk_write_register_address_out,
    output logic [DATA_WIDTH-1:0] non_bulk_write_data_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [4:0]            element_count_out,
    output logic [2:0]            state_out
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COLLECT    = 3'd1,
        S_QUAD_FLUSH = 3'd2,
        S_LAST_WRITE = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    localparam logic [4:0] LAST_QUAD_ELEM = 5'd16;
    localparam logic [4:0] ELEM_16        = 5'd16;
    localparam logic [4:0] ELEM_17        = 5'd17;
    localparam logic [4:0] ELEM_TOTAL     = 5'd18;

    state_t                r_state;
    logic [4:0]            r_count;
    logic [DATA_WIDTH-1:0] r_lane [4];
    logic                  r_qwe;
    logic [2:0]            r_qaddr;
    logic [DATA_WIDTH-1:0] r_qdata [4];
    logic                  r_nbwe;
    logic [4:0]            r_nbaddr;
    logic [DATA_WIDTH-1:0] r_nbdata;

    logic w_ready;
    logic w_accept;

    // Ready only while collecting; abort forces it low so it wins over a handshake.
    always_comb begin
        w_ready  = (r_state == S_COLLECT) && !abort_in;
        w_accept = w_ready && data_valid_in;
    end

    // Main FSM: element counting, lane packing and registered write strobes.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_qwe    <= 1'b0;
            r_qaddr  <= '0;
            r_nbwe   <= 1'b0;
            r_nbaddr <= '0;
            r_nbdata <= '0;
            for (int i = 0; i < 4; i++) begin
                r_lane[i]  <= '0;
                r_qdata[i] <= '0;
            end
        end else begin
            // Strobes are single-cycle; address/data registers keep their value.
            r_qwe  <= 1'b0;
            r_nbwe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    for (int i = 0; i < 4; i++) begin
                        r_lane[i] <= '0;
                    end
                    // The count is cleared only by a new start so that an
                    // aborted load still reports how far it got.
                    if (start_in && !abort_in) begin
                        r_count <= '0;
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (abort_in) begin
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        if (r_count != ELEM_TOTAL) begin
                            r_count <= r_count + 5'd1;
                        end
                        if (r_count < LAST_QUAD_ELEM) begin
                            r_lane[r_count[1:0]] <= data_in;
                            if (r_count[1:0] == 2'd3) begin
                                // Fourth lane bypasses the buffer straight into the write.
                                r_qwe      <= 1'b1;
                                r_qaddr    <= {1'b0, r_count[3:2]};
                                r_qdata[0] <= r_lane[0];
                                r_qdata[1] <= r_lane[1];
                                r_qdata[2] <= r_lane[2];
                                r_qdata[3] <= data_in;
                                r_state    <= S_QUAD_FLUSH;
                            end
                        end else if (r_count == ELEM_16) begin
                            r_nbwe   <= 1'b1;
                            r_nbaddr <= ELEM_16;
                            r_nbdata <= data_in;
                        end else if (r_count == ELEM_17) begin
                            r_nbwe   <= 1'b1;
                            r_nbaddr <= ELEM_17;
                            r_nbdata <= data_in;
                            r_state  <= S_LAST_WRITE;
                        end
                    end
                end
                S_QUAD_FLUSH: begin
                    r_state <= abort_in ? S_IDLE : S_COLLECT;
                end
                S_LAST_WRITE: begin
                    r_state <= abort_in ? S_IDLE : S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output wiring: status flags decode the state register directly.
    always_comb begin
        data_ready_out                      = w_ready;
        quad_write_enable_out               = r_qwe;
        quad_write_register_address_out     = r_qaddr;
        for (int i = 0; i < 4; i++) begin
            quad_write_data_out[i] = r_qdata[i];
        end
        non_bulk_write_enable_out           = r_nbwe;
        non_bulk_write_register_address_out = r_nbaddr;
        non_bulk_write_data_out             = r_nbdata;
        busy_out                            = (r_state != S_IDLE);
        done_out                            = (r_state == S_DONE);
        element_count_out                   = r_count;
        state_out                           = r_state;
    end

endmodule

// File: tb/tb_tensor_core_matrix_loader.sv
// Bench for tensor_core_matrix_loader: cycle table for a continuous load, a
// write scoreboard fed from a reference expansion of the element list, an
// observed register-file image, and hand-written corner-case sequences.
module tb_tensor_core_matrix_loader;

    localparam int DW  = 8;
    localparam int SBW = 38;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          clock_in = 1'b0;
    logic          reset_n_in;
    logic          start_in;
    logic          abort_in;
    logic [DW-1:0] data_in;
    logic          data_valid_in;
    logic          data_ready_out;
    logic          quad_write_enable_out;
    logic [2:0]    quad_write_register_address_out;
    logic [DW-1:0] quad_write_data_out [4];
    logic          non_bulk_write_enable_out;
    logic [4:0]    non_bulk_write_register_address_out;
    logic [DW-1:0] non_bulk_write_data_out;
    logic          busy_out;
    logic          done_out;
    logic [4:0]    element_count_out;
    logic [2:0]    state_out;

    tensor_core_matrix_loader #(.DATA_WIDTH(DW)) dut (
        .clock_in                            (clock_in),
        .reset_n_in                          (reset_n_in),
        .start_in                            (start_in),
        .abort_in                            (abort_in),
        .data_in                             (data_in),
        .data_valid_in                       (data_valid_in),
        .data_ready_out                      (data_ready_out),
        .quad_write_enable_out               (quad_write_enable_out),
        .quad_write_register_address_out     (quad_write_register_address_out),
        .quad_write_data_out                 (quad_write_data_out),
        .non_bulk_write_enable_out           (non_bulk_write_enable_out),
        .non_bulk_write_register_address_out (non_bulk_write_register_address_out),
        .non_bulk_write_data_out             (non_bulk_write_data_out),
        .busy_out                            (busy_out),
        .done_out                            (done_out),
        .element_count_out                   (element_count_out),
        .state_out                           (state_out)
    );

    // ---------------- clock ----------------
    always #5 clock_in = ~clock_in;

    // ---------------- bookkeeping ----------------
    int            n_pass = 0;
    int            n_total = 0;
    int            done_cnt = 0;
    logic [DW-1:0] cur [18];
    logic [DW-1:0] rf_model [18];
    logic [SBW-1:0] exp_q [$];
    logic [SBW-1:0] mon_word;

    typedef struct packed {
        logic       start;
        logic       valid;
        logic       ready;
        logic       qwe;
        logic       nbwe;
        logic       done;
        logic       busy;
        logic [4:0] count;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic s, input logic v, input logic r, input logic q,
                                input logic nb, input logic d, input logic b, input logic [4:0] c);
        vec_t x;
        x.start = s; x.valid = v; x.ready = r; x.qwe = q;
        x.nbwe = nb; x.done = d; x.busy = b; x.count = c;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    function automatic logic [63:0] all_outs();
        return {6'd0, data_ready_out, quad_write_enable_out, quad_write_register_address_out,
                quad_write_data_out[0], quad_write_data_out[1], quad_write_data_out[2],
                quad_write_data_out[3], non_bulk_write_enable_out,
                non_bulk_write_register_address_out, non_bulk_write_data_out,
                busy_out, done_out, element_count_out};
    endfunction

    // ---------------- scoreboard / register-file image ----------------
    task automatic sb_take(input logic [SBW-1:0] got);
        logic [SBW-1:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected_write: got %0h required no write", got);
        end else begin
            e = exp_q.pop_front();
            check("sb_write", {26'd0, got}, {26'd0, e});
        end
    endtask

    always @(negedge clock_in) begin
        if (reset_n_in === 1'b1) begin
            if (quad_write_enable_out || non_bulk_write_enable_out)
                check("enables_exclusive", {63'd0, quad_write_enable_out & non_bulk_write_enable_out}, 64'd0);
            if (quad_write_enable_out) begin
                mon_word = {1'b1, 2'b00, quad_write_register_address_out,
                            quad_write_data_out[0], quad_write_data_out[1],
                            quad_write_data_out[2], quad_write_data_out[3]};
                sb_take(mon_word);
                for (int i = 0; i < 4; i++) begin
                    if ({quad_write_register_address_out, 2'(i)} < 5'd18)
                        rf_model[{quad_write_register_address_out, 2'(i)}] = quad_write_data_out[i];
                end
            end else if (non_bulk_write_enable_out) begin
                mon_word = {1'b0, non_bulk_write_register_address_out, non_bulk_write_data_out, 24'd0};
                sb_take(mon_word);
                if (non_bulk_write_register_address_out < 5'd18)
                    rf_model[non_bulk_write_register_address_out] = non_bulk_write_data_out;
            end
            if (done_out) done_cnt++;
        end
    end

    // ---------------- reference model: element list -> write sequence ----------------
    task automatic push_expected(input int n_quads, input int n_nb);
        for (int q = 0; q < n_quads; q++)
            exp_q.push_back({1'b1, 5'(q), cur[4*q], cur[4*q+1], cur[4*q+2], cur[4*q+3]});
        for (int e = 16; e < 16 + n_nb; e++)
            exp_q.push_back({1'b0, 5'(e), cur[e], 24'd0});
    endtask

    task automatic check_rf(input string name);
        int bad = -1;
        for (int i = 0; i < 18; i++)
            if (bad < 0 && rf_model[i] !== cur[i]) bad = i;
        if (bad < 0) check(name, 64'd0, 64'd0 + {56'd0, 8'(bad < 0 ? 0 : 1)});
        else check($sformatf("%s_elem%0d", name, bad), {56'd0, rf_model[bad]}, {56'd0, cur[bad]});
    endtask

    // ---------------- drivers ----------------
    // Called at posedge+1 in IDLE: one-cycle start pulse, then expect COLLECT.
    task automatic do_start(input string name);
        start_in = 1'b1;
        @(posedge clock_in); #1;
        start_in = 1'b0;
        check(name, {61'd0, busy_out, data_ready_out, (element_count_out == 5'd0)}, 64'd7);
    endtask

    task automatic send_elems(input int n, input int unsigned gap, input bit poke);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 600) begin
            start_in      = 1'b0;
            data_valid_in = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
            data_in       = cur[idx];
            @(negedge clock_in);
            if (poke && (quad_write_enable_out || (data_ready_out && element_count_out == 5'd10)))
                start_in = 1'b1;
            if (data_valid_in && data_ready_out) idx++;
            @(posedge clock_in); #1;
            cyc++;
        end
        start_in      = 1'b0;
        data_valid_in = 1'b0;
        check("send_complete", 64'(idx), 64'(n));
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clock_in);
            if (done_out) seen = 1;
        end
        check(name, {63'd0, seen}, 64'd1);
        @(posedge clock_in); #1;
        check({name, "_idle"}, {58'd0, busy_out, element_count_out}, {58'd0, 1'b0, 5'd18});
    endtask

    task automatic run_full(input string name, input int unsigned gap, input bit poke);
        push_expected(4, 2);
        do_start({name, "_start"});
        send_elems(18, gap, poke);
        wait_done({name, "_done"});
        check_rf({name, "_rf"});
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nxt;
        int d0;
        logic [DW-1:0] prev [18];

        // Continuous-stream cycle table: cycle 0 carries start.
        tbl[0]  = mk(H, L, L, L, L, L, L, 5'd0);
        tbl[1]  = mk(L, H, H, L, L, L, H, 5'd0);
        tbl[2]  = mk(L, H, H, L, L, L, H, 5'd1);
        tbl[3]  = mk(L, H, H, L, L, L, H, 5'd2);
        tbl[4]  = mk(L, H, H, L, L, L, H, 5'd3);
        tbl[5]  = mk(L, H, L, H, L, L, H, 5'd4);
        tbl[6]  = mk(L, H, H, L, L, L, H, 5'd4);
        tbl[7]  = mk(L, H, H, L, L, L, H, 5'd5);
        tbl[8]  = mk(L, H, H, L, L, L, H, 5'd6);
        tbl[9]  = mk(L, H, H, L, L, L, H, 5'd7);
        tbl[10] = mk(L, H, L, H, L, L, H, 5'd8);
        tbl[11] = mk(L, H, H, L, L, L, H, 5'd8);
        tbl[12] = mk(L, H, H, L, L, L, H, 5'd9);
        tbl[13] = mk(L, H, H, L, L, L, H, 5'd10);
        tbl[14] = mk(L, H, H, L, L, L, H, 5'd11);
        tbl[15] = mk(L, H, L, H, L, L, H, 5'd12);
        tbl[16] = mk(L, H, H, L, L, L, H, 5'd12);
        tbl[17] = mk(L, H, H, L, L, L, H, 5'd13);
        tbl[18] = mk(L, H, H, L, L, L, H, 5'd14);
        tbl[19] = mk(L, H, H, L, L, L, H, 5'd15);
        tbl[20] = mk(L, H, L, H, L, L, H, 5'd16);
        tbl[21] = mk(L, H, H, L, L, L, H, 5'd16);
        tbl[22] = mk(L, H, H, L, H, L, H, 5'd17);
        tbl[23] = mk(L, H, L, L, H, L, H, 5'd18);
        tbl[24] = mk(L, H, L, L, L, H, H, 5'd18);
        tbl[25] = mk(L, H, L, L, L, L, L, 5'd18);

        for (int i = 0; i < 18; i++) rf_model[i] = 8'hEE;

        // Reset block.
        reset_n_in    = 1'b0;
        start_in      = 1'b0;
        abort_in      = 1'b0;
        data_valid_in = 1'b0;
        data_in       = '0;
        repeat (2) @(posedge clock_in);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        check("reset_state", {61'd0, state_out}, 64'd0);
        @(negedge clock_in);
        reset_n_in = 1'b1;
        @(posedge clock_in); #1;

        // Continuous stream 0..17 against the cycle table.
        for (int i = 0; i < 18; i++) cur[i] = 8'(i);
        push_expected(4, 2);
        nxt = 0;
        for (int t = 0; t < 26; t++) begin
            start_in      = tbl[t].start;
            data_valid_in = tbl[t].valid;
            data_in       = cur[nxt < 18 ? nxt : 17];
            @(negedge clock_in);
            check($sformatf("tbl_cycle%0d", t),
                  {53'd0, data_ready_out, quad_write_enable_out, non_bulk_write_enable_out,
                   done_out, busy_out, element_count_out},
                  {53'd0, tbl[t].ready, tbl[t].qwe, tbl[t].nbwe, tbl[t].done, tbl[t].busy, tbl[t].count});
            if (data_valid_in && data_ready_out) nxt++;
            @(posedge clock_in); #1;
        end
        start_in      = 1'b0;
        data_valid_in = 1'b0;
        check_rf("stream_rf");
        check("stream_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-load after 7 elements, then a fresh load.
        for (int i = 0; i < 18; i++) cur[i] = 8'($urandom);
        push_expected(4, 2);
        do_start("rst_mid_start");
        send_elems(7, 0, 1'b0);
        #2;
        reset_n_in = 1'b0;
        #1;
        check("rst_mid_outputs", all_outs(), 64'd0);
        check("rst_mid_state", {61'd0, state_out}, 64'd0);
        exp_q.delete();
        #3;
        reset_n_in = 1'b1;
        @(posedge clock_in); #1;
        for (int i = 0; i < 18; i++) cur[i] = cur[i] ^ 8'h5A;
        run_full("rst_fresh", 0, 1'b0);

        // Signed pattern with random valid gaps.
        for (int i = 0; i < 18; i++) cur[i] = (i % 3 == 0) ? 8'h80 : ((i % 3 == 1) ? 8'h7F : 8'hFF);
        run_full("signed_gaps", 40, 1'b0);

        // Abort in the same cycle as element 9's handshake.
        for (int i = 0; i < 18; i++) cur[i] = 8'($urandom);
        push_expected(2, 0);
        do_start("abort_start");
        send_elems(9, 0, 1'b0);
        abort_in      = 1'b1;
        data_valid_in = 1'b1;
        data_in       = cur[9];
        @(negedge clock_in);
        check("abort_ready_low", {63'd0, data_ready_out}, 64'd0);
        d0 = done_cnt;
        @(posedge clock_in); #1;
        abort_in      = 1'b0;
        data_valid_in = 1'b0;
        check("abort_idle", {58'd0, busy_out, element_count_out}, {58'd0, 1'b0, 5'd9});
        repeat (6) @(posedge clock_in);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        check("abort_count_hold", {59'd0, element_count_out}, 64'd9);
        check("abort_sb_empty", 64'(exp_q.size()), 64'd0);

        // Start pulses during QUAD_FLUSH and COLLECT are ignored.
        for (int i = 0; i < 18; i++) cur[i] = 8'($urandom);
        run_full("start_ignored", 0, 1'b1);

        // Back-to-back: second start in the cycle right after done.
        for (int i = 0; i < 18; i++) prev[i] = cur[i];
        for (int i = 0; i < 18; i++) cur[i] = ~prev[i];
        run_full("b2b", 20, 1'b0);

        // Randomised loads.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 18; i++) cur[i] = 8'($urandom);
            run_full($sformatf("rand%0d", r), 30, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Time bound so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule

// File: doc/tensor_core_matrix_loader.md
# tensor_core_matrix_loader

Streams the 18 signed 8-bit operand elements of the tensor core (two 3x3 matrices, row-major, matrix 0 first) from a byte-wide valid/ready source into `tensor_core_register_file`. Elements 0-15 are packed four at a time and issued as quad writes at quad addresses 0-3. Elements 16-17 are issued as single non-bulk writes. The block sits directly upstream of the register file's write ports and signals completion so the tensor core can start.

## Interface
- `DATA_WIDTH`, default 8: element width; elements are signed two's complement.
- `clock_in`  input  1  sole clock; all state updates on the rising edge.
- `reset_n_in`  input  1  asynchronous, active-low reset.
- `start_in`  input  1  begins a load when sampled high in IDLE; ignored in every other state.
- `abort_in`  input  1  cancels a load in progress; returns to IDLE on the next edge.
- `data_in`  input  DATA_WIDTH  signed element from the source.
- `data_valid_in`  input  1  source has an element on `data_in`.
- `data_ready_out`  output  1  loader accepts `data_in` this cycle; combinational: (state==COLLECT) && !abort_in.
- `quad_write_enable_out`  output  1  quad write strobe to the register file; registered.
- `quad_write_register_address_out`  output  3  quad address 0-3; registered.
- `quad_write_data_out[4]`  output  DATA_WIDTH each  lane i holds element 4*addr+i; registered.
- `non_bulk_write_enable_out`  output  1  single-element write strobe; registered.
- `non_bulk_write_register_address_out`  output  5  element address, 16 or 17 only; registered.
- `non_bulk_write_data_out`  output  DATA_WIDTH  element value; registered.
- `busy_out`  output  1  high in every state except IDLE.
- `done_out`  output  1  one-cycle pulse after the last write has been presented.
- `element_count_out`  output  5  number of elements accepted since the last start, range 0-18.

## Operation
- States: IDLE, COLLECT, QUAD_FLUSH, LAST_WRITE, DONE.
- IDLE:
  - `start_in` high and `abort_in` low -> COLLECT.
  - Clears `element_count_out` and the lane buffer.
- COLLECT: a handshake (`data_valid_in` && `data_ready_out`) stores `data_in` and increments the count `c` (value before increment).
  - c<16: store into lane `c%4`. When c%4==3 -> QUAD_FLUSH.
  - c==16: register a non-bulk write of address 16; stay in COLLECT.
  - c==17: register a non-bulk write of address 17 -> LAST_WRITE.
- QUAD_FLUSH (one cycle):
  - `quad_write_enable_out`=1, address = c/4, data = the four lanes.
  - Ready is low.
  - Next state is COLLECT.
- LAST_WRITE (one cycle): the non-bulk write of element 17 is on the outputs; next state DONE.
- DONE (one cycle): `done_out`=1; next state IDLE.
- Write enables are single-cycle pulses and are never asserted together.
  - Data and address outputs hold their last value when the enables are low.
- Abort in any non-IDLE state:
  - Next state is IDLE with all enables low and no `done_out`.
  - Already-issued writes are not undone.
  - `element_count_out` holds its value.
  - `abort_in` wins over a same-cycle handshake; `data_ready_out` is forced low, so no element is accepted.
- `start_in` together with `abort_in` in IDLE: stay in IDLE.
- `element_count_out` saturates at 18 and holds until the next start.
- Elements pass through unmodified; there is no sign extension or arithmetic.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state IDLE.
  - Outputs 0: `data_ready_out`, `busy_out`, `done_out`, both enables, all addresses and data, `element_count_out`.
- `start_in` sampled at edge E -> COLLECT and `data_ready_out` high in the cycle after E.
- 4th element of a quad accepted in cycle k:
  - Cycle k+1: quad write pulse, ready low.
  - Cycle k+2: ready high again.
- Element 16 accepted in cycle k -> non-bulk write presented in cycle k+1. Ready stays high in k+1.
- Element 17 accepted in cycle k:
  - Cycle k+1: non-bulk write (LAST_WRITE).
  - Cycle k+2: `done_out` (DONE).
  - Cycle k+3: IDLE.
- With `data_valid_in` held high and start sampled at the end of cycle 0:
  - Quads are presented in cycles 5, 10, 15 and 20.
  - Element 16 is written in cycle 22 and element 17 in cycle 23.
  - `done_out` pulses in cycle 24; `busy_out` falls in cycle 25.
- Source stalls (valid low) insert idle cycles without changing state; no timeout.

## Test plan
- Reset mid-load:
  - Stimulus: assert `reset_n_in` low asynchronously after 7 elements.
  - Response: all outputs 0 immediately, state IDLE.
  - Stimulus: then start a fresh load.
  - Response: completes normally, with quad 0 rewritten from the new data.
- Continuous stream 0..17 after start:
  - Quad writes at addresses 0/1/2/3 carry {0,1,2,3}/{4,5,6,7}/{8,9,10,11}/{12,13,14,15}.
  - Non-bulk writes are address 16 = 16, then address 17 = 17.
  - `done_out` pulses in cycle 24; the register file bulk read matches 0..17.
- Signed data and random valid gaps:
  - Stimulus: stream of -128, 127, -1 repeating, with valid dropped at random.
  - Response: identical write contents; no element is lost or duplicated; enables are never high together.
- Abort:
  - Stimulus: `abort_in` in the same cycle as the handshake of element 9.
  - Response: element 9 not accepted; IDLE next cycle; `element_count_out`=9; no `done_out`; no further writes.
- Start ignored while busy:
  - Stimulus: pulse `start_in` during QUAD_FLUSH and during COLLECT.
  - Response: count is not cleared and the load finishes unchanged.
- Back-to-back loads:
  - Stimulus: start sampled in the cycle after `done_out`.
  - Response: second load begins; `element_count_out` clears to 0; the new data overwrites all 18 registers.
